hc595_chain_driver: RTL and testbench

//  Parametrised serial driver for a chain of NUM_CHIPS cascaded 74HC595 shift registers (segment/bit-select or LED banks).

---
 rtl/hc595_pkg.sv | 25 ++
 rtl/hc595_chain_driver_if.sv | 35 +++
 rtl/hc595_tick_gen.sv | 42 ++++
 rtl/hc595_chain_driver.sv | 174 +++++++++++++++++
 tb/tb_hc595_chain_driver.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hc595_pkg.sv
// ---------------------------------------------------------------------------
// hc595_pkg
// Shared definitions for the 74HC595 chain driver:
//   - BITS_PER_CHIP : width of one 595 shift register
//   - state_t       : transfer FSM state encoding
//   - clog2_min1    : counter-width helper that never returns zero
// ---------------------------------------------------------------------------
package hc595_pkg;

    localparam int BITS_PER_CHIP = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SH_LO  = 3'd1,
        ST_SH_HI  = 3'd2,
        ST_LT_SET = 3'd3,
        ST_LT_HI  = 3'd4
    } state_t;

    // Width of a counter holding 0..n-1; a divide-by-1 counter still needs one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hc595_chain_driver_if.sv
// ---------------------------------------------------------------------------
// hc595_chain_driver_if
// Word-level request side of the 595 chain driver.
//   data_in    : parallel word to shift out (W bits)
//   data_valid : word available
//   data_ready : driver idle; word accepted when data_valid && data_ready
//   blank      : 1 forces the 595 outputs off
//   done       : one-cycle pulse once the word has been latched
// master = word source, slave = chain driver.
// ---------------------------------------------------------------------------
interface hc595_chain_driver_if #(
    parameter int W = 16
);
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         blank;
    logic         done;

    modport master (
        output data_in,
        output data_valid,
        output blank,
        input  data_ready,
        input  done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  blank,
        output data_ready,
        output done
    );
endinterface

// File: rtl/hc595_tick_gen.sv
// ---------------------------------------------------------------------------
// hc595_tick_gen
// Divides clk by CLK_DIV and produces a one-cycle tick enable every CLK_DIV
// cycles. clr restarts the count so the first tick after a clear arrives
// exactly CLK_DIV cycles later.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   clr   in  synchronous counter clear
//   tick  out high on the last cycle of each CLK_DIV period
// ---------------------------------------------------------------------------
module hc595_tick_gen
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = clog2_min1(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Free-running divide counter with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// ---------------------------------------------------------------------------
// hc595_chain_driver
// Serial driver for NUM_CHIPS cascaded 74HC595s. A word accepted over the
// valid/ready interface is shifted out on ds/shcp (one tick per shcp level),
// then stcp is pulsed to latch it and done is pulsed for one cycle.
// oe stays high (outputs off) from reset until the first complete latch, so
// the chain never shows garbage; after that oe follows blank.
// Ports:
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   bus        slave side of hc595_chain_driver_if (data/valid/ready/blank/done)
//   shcp       out shift clock to the chain
//   ds         out serial data to the first 595
//   stcp       out storage (latch) clock
//   oe         out output enable, active-low
// All outputs are registered.
// ---------------------------------------------------------------------------
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    hc595_chain_driver_if.slave  bus,
    output logic                 shcp,
    output logic                 ds,
    output logic                 stcp,
    output logic                 oe
);
    localparam int W   = BITS_PER_CHIP * NUM_CHIPS;
    localparam int BCW = $clog2(W + 1);

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   sreg_r;
    logic [W-1:0]   sreg_s;
    logic [BCW-1:0] bit_cnt_r;
    logic [BCW-1:0] bit_cnt_s;
    logic           armed_r;
    logic           armed_s;
    logic           ready_r;
    logic           done_r;
    logic           done_s;
    logic           accept_s;
    logic           tick_s;
    logic           head_s;
    logic           ds_s;
    logic           shcp_r;
    logic           ds_r;
    logic           stcp_r;
    logic           oe_r;

    hc595_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (accept_s),
        .tick  (tick_s)
    );

    // Next-state logic: FSM, shift register and bit counter
    always_comb begin
        state_s   = state_r;
        sreg_s    = sreg_r;
        bit_cnt_s = bit_cnt_r;
        done_s    = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.data_valid && ready_r) begin
                    accept_s  = 1'b1;
                    sreg_s    = bus.data_in;
                    bit_cnt_s = '0;
                    state_s   = ST_SH_LO;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SH_LO: begin
                if (tick_s) begin
                    state_s = ST_SH_HI;
                end else begin
                    state_s = ST_SH_LO;
                end
            end
            ST_SH_HI: begin
                if (tick_s) begin
                    // The bit just clocked in leaves; the next one moves to the head
                    if (MSB_FIRST) begin
                        sreg_s = {sreg_r[W-2:0], 1'b0};
                    end else begin
                        sreg_s = {1'b0, sreg_r[W-1:1]};
                    end
                    if (bit_cnt_r == BCW'(W - 1)) begin
                        state_s = ST_LT_SET;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BCW'(1);
                        state_s   = ST_SH_LO;
                    end
                end else begin
                    state_s = ST_SH_HI;
                end
            end
            ST_LT_SET: begin
                if (tick_s) begin
                    state_s = ST_LT_HI;
                end else begin
                    state_s = ST_LT_SET;
                end
            end
            ST_LT_HI: begin
                if (tick_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_LT_HI;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so pins change together with the state
    always_comb begin
        head_s  = MSB_FIRST ? sreg_s[W-1] : sreg_s[0];
        armed_s = armed_r | done_s;
        if ((state_s == ST_SH_LO) || (state_s == ST_SH_HI)) begin
            ds_s = head_s;
        end else begin
            ds_s = 1'b0;
        end
    end

    // State, datapath and registered pin outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            sreg_r    <= '0;
            bit_cnt_r <= '0;
            armed_r   <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            shcp_r    <= 1'b0;
            ds_r      <= 1'b0;
            stcp_r    <= 1'b0;
            oe_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            sreg_r    <= sreg_s;
            bit_cnt_r <= bit_cnt_s;
            armed_r   <= armed_s;
            ready_r   <= (state_s == ST_IDLE);
            done_r    <= done_s;
            shcp_r    <= (state_s == ST_SH_HI);
            ds_r      <= ds_s;
            stcp_r    <= (state_s == ST_LT_HI);
            oe_r      <= armed_s ? bus.blank : 1'b1;
        end
    end

    assign bus.data_ready = ready_r;
    assign bus.done       = done_r;
    assign shcp           = shcp_r;
    assign ds             = ds_r;
    assign stcp           = stcp_r;
    assign oe             = oe_r;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// ---------------------------------------------------------------------------
// tb_hc595_chain_driver
// Two instances: dut_a (2 chips, CLK_DIV=2, MSB first) and dut_b (2 chips,
// CLK_DIV=1, LSB first). A negedge monitor collects ds at every shcp rise,
// compares the stream against the expected word at each stcp rise, checks
// stcp pulse width, accept->done latency and the oe/blank rule every cycle.
// ---------------------------------------------------------------------------
module tb_hc595_chain_driver;

    logic clk;
    logic rst_n;
    logic shcp_a, ds_a, stcp_a, oe_a;
    logic shcp_b, ds_b, stcp_b, oe_b;

    hc595_chain_driver_if #(.W(16)) bus_a ();
    hc595_chain_driver_if #(.W(16)) bus_b ();

    hc595_chain_driver #(.NUM_CHIPS(2), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
        .sys_clk (clk), .sys_rst_n (rst_n), .bus (bus_a),
        .shcp (shcp_a), .ds (ds_a), .stcp (stcp_a), .oe (oe_a)
    );

    hc595_chain_driver #(.NUM_CHIPS(2), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
        .sys_clk (clk), .sys_rst_n (rst_n), .bus (bus_b),
        .shcp (shcp_b), .ds (ds_b), .stcp (stcp_b), .oe (oe_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected streams (first shifted bit at [15]) and accept cycles per DUT
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          acc_a[$];
    int          acc_b[$];

    // Monitor state per DUT
    logic        sh_p[2];
    logic        st_p[2];
    logic        blank_p[2];
    bit          armed[2];
    logic [15:0] got[2];
    int          nbits[2];
    int          st_w[2];
    int          rises[2];
    int          stcp_rises[2];

    typedef struct {
        logic [15:0] data;
        logic [15:0] stream_msb;
        logic [15:0] stream_lsb;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] stream_of(input logic [15:0] w, input bit msb);
        logic [15:0] s;
        for (int i = 0; i < 16; i++) s[15-i] = msb ? w[15-i] : w[i];
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic mon(input int k, input logic sh, input logic d, input logic st,
                       input logic dn, input logic o, input logic bl);
        string p;
        logic [15:0] front;
        int acc;
        int lat;
        p = (k == 0) ? "a" : "b";
        if (!rst_n) begin
            sh_p[k] = 1'b0; st_p[k] = 1'b0; nbits[k] = 0; st_w[k] = 0;
            armed[k] = 1'b0; blank_p[k] = bl;
            return;
        end
        if (sh && !sh_p[k]) begin
            got[k] = {got[k][14:0], d};
            nbits[k]++;
            rises[k]++;
        end
        if (st) st_w[k]++;
        if (st && !st_p[k]) begin
            stcp_rises[k]++;
            chk({p, "_bits_per_latch"}, nbits[k], 16);
            chk({p, "_latch_expected"}, ((k == 0) ? exp_a.size() : exp_b.size()) > 0, 1);
            front = (k == 0) ? ((exp_a.size() > 0) ? exp_a[0] : 16'h0)
                             : ((exp_b.size() > 0) ? exp_b[0] : 16'h0);
            chk({p, "_stream"}, got[k], front);
            nbits[k] = 0;
        end
        if (!st && st_p[k]) begin
            chk({p, "_stcp_width"}, st_w[k], (k == 0) ? 2 : 1);
            st_w[k] = 0;
        end
        if (dn) begin
            chk({p, "_done_expected"}, ((k == 0) ? acc_a.size() : acc_b.size()) > 0, 1);
            if (k == 0 && acc_a.size() > 0) begin
                acc = acc_a.pop_front(); void'(exp_a.pop_front());
                lat = cyc - acc;
                chk("a_latency", lat, 68);
            end else if (k == 1 && acc_b.size() > 0) begin
                acc = acc_b.pop_front(); void'(exp_b.pop_front());
                lat = cyc - acc;
                chk("b_latency", lat, 34);
            end
            armed[k] = 1'b1;
        end
        chk({p, "_oe"}, o, armed[k] ? blank_p[k] : 1'b1);
        blank_p[k] = bl;
        sh_p[k]    = sh;
        st_p[k]    = st;
    endtask

    initial forever begin
        @(negedge clk);
        mon(0, shcp_a, ds_a, stcp_a, bus_a.done, oe_a, bus_a.blank);
        mon(1, shcp_b, ds_b, stcp_b, bus_b.done, oe_b, bus_b.blank);
    end

    task automatic send(input int k, input logic [15:0] w, input logic [15:0] stream,
                        input bit keep, output int acc);
        int n;
        n = 0;
        if (k == 0) begin bus_a.data_in = w; bus_a.data_valid = 1'b1; end
        else        begin bus_b.data_in = w; bus_b.data_valid = 1'b1; end
        while ((((k == 0) ? bus_a.data_ready : bus_b.data_ready) !== 1'b1) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk((k == 0) ? "a_accept_timeout" : "b_accept_timeout", n < 300, 1);
        acc = cyc + 1;
        if (k == 0) begin exp_a.push_back(stream); acc_a.push_back(acc); end
        else        begin exp_b.push_back(stream); acc_b.push_back(acc); end
        @(posedge clk); #1;
        if (!keep) begin
            if (k == 0) bus_a.data_valid = 1'b0;
            else        bus_b.data_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", n < 400, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_blank(input logic b);
        bus_a.blank = b;
        bus_b.blank = b;
    endtask

    initial begin
        int acc1, acc2, accb, n, base, st0;
        logic [15:0] wa, wb;

        tbl[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
        tbl[1] = '{16'h0001, 16'h0001, 16'h8000};
        tbl[2] = '{16'h8000, 16'h8000, 16'h0001};
        tbl[3] = '{16'h1234, 16'h1234, 16'h2C48};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000};

        rst_n = 1'b0;
        bus_a.data_in = 16'h0; bus_a.data_valid = 1'b0;
        bus_b.data_in = 16'h0; bus_b.data_valid = 1'b0;
        set_blank(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_shcp", shcp_a, 1'b0);
        chk("rst_ds", ds_a, 1'b0);
        chk("rst_stcp", stcp_a, 1'b0);
        chk("rst_oe", oe_a, 1'b1);
        chk("rst_ready", bus_a.data_ready, 1'b1);
        chk("rst_done", bus_a.done, 1'b0);
        chk("rst_oe_b", oe_b, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors: same word into both bit orders
        for (int i = 0; i < 6; i++) begin
            fork
                send(0, tbl[i].data, tbl[i].stream_msb, 1'b0, acc1);
                send(1, tbl[i].data, tbl[i].stream_lsb, 1'b0, accb);
            join
            wait_idle();
        end
        chk("oe_after_latch", oe_a, 1'b0);

        // Blanking with one-cycle latency
        set_blank(1'b1);
        @(posedge clk); #1;
        chk("blank_on_a", oe_a, 1'b1);
        chk("blank_on_b", oe_b, 1'b1);
        set_blank(1'b0);
        @(posedge clk); #1;
        chk("blank_off_a", oe_a, 1'b0);

        // Back-to-back with valid held high
        base = rises[0];
        st0  = stcp_rises[0];
        send(0, 16'h1234, 16'h1234, 1'b1, acc1);
        send(0, 16'hFFFF, 16'hFFFF, 1'b0, acc2);
        chk("b2b_accept_gap", acc2 - acc1, 69);
        wait_idle();
        chk("b2b_shcp_rises", rises[0] - base, 32);
        chk("b2b_stcp_rises", stcp_rises[0] - st0, 2);

        // valid pulse while busy must be ignored
        st0 = stcp_rises[0];
        send(0, 16'h5A3C, 16'h5A3C, 1'b0, acc1);
        repeat (10) @(posedge clk);
        #1;
        bus_a.data_in = 16'h0000; bus_a.data_valid = 1'b1;
        chk("busy_ready", bus_a.data_ready, 1'b0);
        @(posedge clk); #1;
        bus_a.data_valid = 1'b0;
        wait_idle();
        repeat (80) @(posedge clk);
        #1;
        chk("busy_single_latch", stcp_rises[0] - st0, 1);

        // Reset after five shift clocks
        base = rises[0];
        st0  = stcp_rises[0];
        send(0, 16'hA5C3, 16'hA5C3, 1'b0, acc1);
        n = 0;
        while ((rises[0] - base) < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_wait_timeout", n < 200, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_shcp", shcp_a, 1'b0);
        chk("abort_ds", ds_a, 1'b0);
        chk("abort_stcp", stcp_a, 1'b0);
        chk("abort_oe", oe_a, 1'b1);
        chk("abort_ready", bus_a.data_ready, 1'b1);
        exp_a.delete(); acc_a.delete(); exp_b.delete(); acc_b.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("abort_no_latch", stcp_rises[0] - st0, 0);
        chk("abort_oe_held", oe_a, 1'b1);

        // Randomized words against the stream model
        for (int i = 0; i < 16; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            set_blank(1'($urandom_range(0, 1)));
            fork
                send(0, wa, stream_of(wa, 1'b1), 1'b0, acc1);
                send(1, wb, stream_of(wb, 1'b0), 1'b0, accb);
            join
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
